// File: rtl/bambu_mem_pkg.sv
// Shared types and helpers for the Bambu memory lane arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bambu_mem_pkg;

  localparam int LANES = 2;

  typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT, RESP} arb_state_t;

  // Bit write mask covering the low 'size' bits; sizes at or above the word width select every bit.
  function automatic logic [63:0] size_to_mask(input int size, input int data_w);
    logic [63:0] m;
    if (size >= data_w || size >= 64) m = '1;
    else                              m = (64'd1 << size) - 64'd1;
    return m;
  endfunction

endpackage

// File: rtl/bambu_rr_arb2.sv
// Two-requester round-robin picker holding the last granted index.
// Latency: combinational pick, last_grant updates on the clock after 'update'.
// Backpressure: none; the caller decides when a pick is consumed via 'update'.
module bambu_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic       gnt
);

  logic last_grant;

  always_comb begin
    gnt = 1'b0;
    if (req == 2'b11) gnt = ~last_grant;
    else if (req[1])  gnt = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)       last_grant <= 1'b1;
    else if (update) last_grant <= gnt;
  end

endmodule

// File: rtl/bambu_mem_lane_arbiter.sv
// Shares one single-port synchronous memory between two Bambu master lanes.
// Latency: lane_rdy pulses READ_DELAY / WRITE_DELAY cycles after the mem_en cycle.
// Backpressure: requests are level-held until lane_rdy; one transaction in flight at a time.
module bambu_mem_lane_arbiter
  import bambu_mem_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SIZE_W      = 4,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1,
  parameter int BASE_ADDR   = 0,
  parameter int MEMSIZE     = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [LANES-1:0]           lane_oe,
  input  logic [LANES-1:0]           lane_we,
  input  logic [LANES*ADDR_W-1:0]    lane_addr,
  input  logic [LANES*DATA_W-1:0]    lane_wdata,
  input  logic [LANES*SIZE_W-1:0]    lane_size,
  output logic [LANES*DATA_W-1:0]    lane_rdata,
  output logic [LANES-1:0]           lane_rdy,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [DATA_W-1:0]          mem_wmask,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       err_both,
  output logic                       busy
);

  localparam int MAX_DLY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int CNT_W   = $clog2(MAX_DLY + 1);

  typedef struct packed {
    logic              lane;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdat;
    logic [DATA_W-1:0] mask;
  } grant_t;

  arb_state_t        state;
  grant_t            grant_q;
  grant_t            grant_d;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rd_dat;
  logic [LANES-1:0]  req_vld;
  logic              gnt_lane;
  logic              arb_update;
  int                dly_cur;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      req_vld[i] = (lane_oe[i] ^ lane_we[i])
                && (int'(lane_addr[i*ADDR_W +: ADDR_W]) >= BASE_ADDR)
                && (int'(lane_addr[i*ADDR_W +: ADDR_W]) <  BASE_ADDR + MEMSIZE);
    end
  end

  assign arb_update = (state == IDLE) && (|req_vld);

  bambu_rr_arb2 u_rr (
    .clock  (clock),
    .reset  (reset),
    .req    (req_vld),
    .update (arb_update),
    .gnt    (gnt_lane)
  );

  always_comb begin
    grant_d.lane = gnt_lane;
    grant_d.we   = gnt_lane ? lane_we[1] : lane_we[0];
    grant_d.addr = gnt_lane
                 ? ADDR_W'(int'(lane_addr[2*ADDR_W-1:ADDR_W]) - BASE_ADDR)
                 : ADDR_W'(int'(lane_addr[ADDR_W-1:0])        - BASE_ADDR);
    grant_d.wdat = gnt_lane ? lane_wdata[2*DATA_W-1:DATA_W] : lane_wdata[DATA_W-1:0];
    grant_d.mask = gnt_lane
                 ? DATA_W'(size_to_mask(int'(lane_size[2*SIZE_W-1:SIZE_W]), DATA_W))
                 : DATA_W'(size_to_mask(int'(lane_size[SIZE_W-1:0]),        DATA_W));
  end

  assign dly_cur = grant_q.we ? WRITE_DELAY : READ_DELAY;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      grant_q   <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      lane_rdy  <= '0;
      err_both  <= 1'b0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      lane_rdy  <= '0;
      if (|(lane_oe & lane_we)) err_both <= 1'b1;

      case (state)
        IDLE: begin
          if (|req_vld) begin
            grant_q <= grant_d;
            state   <= GRANT;
          end
        end
        GRANT: begin
          mem_en    <= 1'b1;
          mem_we    <= grant_q.we;
          mem_addr  <= grant_q.addr;
          mem_wdata <= grant_q.wdat;
          mem_wmask <= grant_q.mask;
          state     <= ISSUE;
        end
        ISSUE: begin
          cnt <= CNT_W'(1);
          // A one-cycle delay has no room for a WAIT cycle, so respond straight away.
          if (dly_cur <= 1) begin
            lane_rdy[grant_q.lane] <= 1'b1;
            state                  <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(1) && !grant_q.we) rdata_q <= mem_rdata;
          if (int'(cnt) + 1 >= dly_cur) begin
            lane_rdy[grant_q.lane] <= 1'b1;
            state                  <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // With a one-cycle read delay the memory output is only valid during RESP itself.
  assign rd_dat = (READ_DELAY == 1) ? mem_rdata : rdata_q;

  always_comb begin
    lane_rdata = '0;
    if (!grant_q.we && (|lane_rdy)) begin
      if (grant_q.lane) lane_rdata[2*DATA_W-1:DATA_W] = rd_dat;
      else              lane_rdata[DATA_W-1:0]        = rd_dat;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bambu_mem_lane_arbiter.sv
// Directed bench for bambu_mem_lane_arbiter with a small synchronous memory model.
// Latency: drives at posedge+1, samples at posedge+1.
// Backpressure: requests held until lane_rdy, then dropped.
module tb_bambu_mem_lane_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  lane_oe, lane_we;
  logic [13:0] lane_addr;
  logic [15:0] lane_wdata;
  logic [7:0]  lane_size;
  logic [15:0] lane_rdata;
  logic [1:0]  lane_rdy;
  logic        mem_en, mem_we;
  logic [6:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_wmask;
  logic [7:0]  mem_rdata = 8'h00;
  logic        err_both, busy;

  logic [7:0]  mem [0:3];
  int checks = 0, failures = 0;
  int cyc = 0;
  int en_cnt = 0, rdy_cnt = 0, busy_cnt = 0, we_cnt = 0;

  bambu_mem_lane_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .lane_oe    (lane_oe),
    .lane_we    (lane_we),
    .lane_addr  (lane_addr),
    .lane_wdata (lane_wdata),
    .lane_size  (lane_size),
    .lane_rdata (lane_rdata),
    .lane_rdy   (lane_rdy),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rdata  (mem_rdata),
    .err_both   (err_both),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc++;
    if (mem_en === 1'b1) en_cnt++;
    if (mem_en === 1'b1 && mem_we === 1'b1) we_cnt++;
    if (lane_rdy !== 2'b00) rdy_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1)
        mem[mem_addr[1:0]] = (mem[mem_addr[1:0]] & ~mem_wmask) | (mem_wdata & mem_wmask);
      else
        mem_rdata <= mem[mem_addr[1:0]];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_issue(input string tag, output int t);
    int n;
    n = 0;
    while (mem_en !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    assert (mem_en === 1'b1) else begin
      failures++;
      $error("FAIL %s_issue: observed mem_en=%0b expected 1 within 20 cycles", tag, mem_en);
    end
    t = cyc;
  endtask

  task automatic expect_read(input string tag, input logic [1:0] rdy, input logic [15:0] dat,
                             output int t);
    wait_issue(tag, t);
    chk({tag, "_we"}, 32'(mem_we), 32'h0);
    tick();
    tick();
    chk({tag, "_rdy"}, 32'(lane_rdy), 32'(rdy));
    chk({tag, "_dat"}, 32'(lane_rdata), 32'(dat));
    chk({tag, "_lat"}, 32'(cyc - t), 32'd2);
  endtask

  initial begin
    int t1, t2, e0, r0, b0, w0;
    reset      = 1'b1;
    lane_oe    = 2'b00;
    lane_we    = 2'b00;
    lane_addr  = '0;
    lane_wdata = '0;
    lane_size  = '0;
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_rdy",   32'(lane_rdy),   32'h0);
    chk("rst_en",    32'(mem_en),     32'h0);
    chk("rst_busy",  32'(busy),       32'h0);
    chk("rst_err",   32'(err_both),   32'h0);
    chk("rst_rdata", 32'(lane_rdata), 32'h0);
    chk("rst_addr",  32'(mem_addr),   32'h0);

    // Lane 0 read, READ_DELAY=2
    mem[0]  = 8'hA5;
    lane_oe = 2'b01;
    expect_read("rd0", 2'b01, 16'h00A5, t1);
    lane_oe = 2'b00;
    tick();
    chk("rd0_idle_busy", 32'(busy),     32'h0);
    chk("rd0_idle_rdy",  32'(lane_rdy), 32'h0);

    // Lane 1 write, size 4 -> low nibble only
    mem[0]     = 8'hF0;
    lane_we    = 2'b10;
    lane_wdata = {8'h3C, 8'h00};
    lane_size  = {4'd4, 4'd0};
    wait_issue("wr1", t1);
    chk("wr1_we",    32'(mem_we),    32'h1);
    chk("wr1_mask",  32'(mem_wmask), 32'h0F);
    chk("wr1_wdata", 32'(mem_wdata), 32'h3C);
    chk("wr1_addr",  32'(mem_addr),  32'h0);
    tick();
    chk("wr1_rdy",   32'(lane_rdy),   32'h2);
    chk("wr1_rdata", 32'(lane_rdata), 32'h0);
    chk("wr1_mem",   32'(mem[0]),     32'hFC);
    chk("wr1_lat",   32'(cyc - t1),   32'd1);
    lane_we = 2'b00;
    tick();

    // Both lanes read together after reset: lane 0 first, then alternation
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    mem[0] = 8'h5A;
    for (int p = 0; p < 2; p++) begin
      lane_oe = 2'b11;
      expect_read($sformatf("rr%0d_a", p), 2'b01, 16'h005A, t1);
      lane_oe[0] = 1'b0;
      expect_read($sformatf("rr%0d_b", p), 2'b10, 16'h5A00, t2);
      chk($sformatf("rr%0d_gap", p), 32'(t2 - t1), 32'd5);
      lane_oe = 2'b00;
      tick();
    end

    // Lane 0 oe&we together while lane 1 reads
    mem[0]  = 8'h33;
    w0      = we_cnt;
    lane_oe = 2'b11;
    lane_we = 2'b01;
    tick();
    chk("both_err", 32'(err_both), 32'h1);
    expect_read("both_l1", 2'b10, 16'h3300, t1);
    lane_oe[1] = 1'b0;
    e0 = en_cnt;
    repeat (10) tick();
    chk("both_no_en", 32'(en_cnt - e0), 32'h0);
    chk("both_no_we", 32'(we_cnt - w0), 32'h0);
    chk("both_sticky", 32'(err_both), 32'h1);
    lane_oe = 2'b00;
    lane_we = 2'b00;
    tick();
    chk("both_sticky2", 32'(err_both), 32'h1);

    // Reset during WAIT of a read aborts it
    mem[0]  = 8'h77;
    lane_oe = 2'b01;
    wait_issue("abort", t1);
    tick();
    chk("abort_wait_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    chk("abort_rdy",   32'(lane_rdy),   32'h0);
    chk("abort_busy",  32'(busy),       32'h0);
    chk("abort_en",    32'(mem_en),     32'h0);
    chk("abort_err",   32'(err_both),   32'h0);
    chk("abort_rdata", 32'(lane_rdata), 32'h0);
    tick();
    chk("abort_rdy2",  32'(lane_rdy),   32'h0);
    reset = 1'b0;
    expect_read("abort_after", 2'b01, 16'h0077, t1);
    lane_oe = 2'b00;
    tick();

    // Out-of-window address is never served
    lane_addr = {7'h00, 7'h05};
    lane_oe   = 2'b01;
    e0 = en_cnt;
    r0 = rdy_cnt;
    b0 = busy_cnt;
    repeat (20) tick();
    chk("oow_en",   32'(en_cnt - e0),   32'h0);
    chk("oow_rdy",  32'(rdy_cnt - r0),  32'h0);
    chk("oow_busy", 32'(busy_cnt - b0), 32'h0);
    chk("oow_busy_now", 32'(busy), 32'h0);
    lane_oe = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
